// File: rtl/log_position_tracker_if.sv
// Bundle of load offsets, frame control and read-port signals for the log position tracker.
interface log_position_tracker_if #(
    parameter int unsigned NUM_OF_LOGS = 30
);
    logic [NUM_OF_LOGS-1:0][8:0] start_offsetX;
    logic [NUM_OF_LOGS-1:0][8:0] start_offsetY;
    logic                        restart;
    logic                        startOfFrame;
    logic                        rd_valid;
    logic [4:0]                  rd_index;
    logic                        ready;
    logic                        frame_done;
    logic                        overrun;
    logic                        rd_ack;
    logic [9:0]                  rd_x;
    logic [8:0]                  rd_y;
    logic                        rd_err;

    modport master (
        output start_offsetX, start_offsetY, restart, startOfFrame, rd_valid, rd_index,
        input  ready, frame_done, overrun, rd_ack, rd_x, rd_y, rd_err
    );

    modport slave (
        input  start_offsetX, start_offsetY, restart, startOfFrame, rd_valid, rd_index,
        output ready, frame_done, overrun, rd_ack, rd_x, rd_y, rd_err
    );
endinterface

// File: rtl/log_position_tracker.sv
// Tracks per-log X/Y screen positions: loads from offsets, advances X once per frame with wrap,
// and serves a registered read port in every state.
module log_position_tracker #(
    parameter int unsigned NUM_OF_LOGS = 30,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned LOG_SPEED   = 1
) (
    input logic                   CLK,
    input logic                   RST,
    log_position_tracker_if.slave bus
);
    localparam logic [4:0]  IdxLast = 5'(NUM_OF_LOGS - 1);
    localparam logic [10:0] ScreenW = 11'(SCREEN_W);
    localparam logic [10:0] Speed   = 11'(LOG_SPEED);

    typedef enum logic [1:0] {StLoad, StIdle, StMove} state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;
    logic        rd_ack_q, rd_err_q;
    logic [9:0]  rd_x_q;
    logic [8:0]  rd_y_q;

    logic [9:0]  x_q [NUM_OF_LOGS];
    logic [8:0]  y_q [NUM_OF_LOGS];

    logic        wr_x_en, wr_y_en;
    logic [9:0]  x_wr;
    logic [10:0] load_sum, move_sum;
    logic        rd_oob;

    always_comb begin
        load_sum     = {2'b00, bus.start_offsetX[idx_q]};
        move_sum     = {1'b0, x_q[idx_q]} + Speed;
        state_d      = state_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (bus.startOfFrame && (state_q != StIdle));
        wr_x_en      = 1'b0;
        wr_y_en      = 1'b0;
        x_wr         = '0;
        case (state_q)
            StLoad: begin
                if (bus.restart) begin
                    idx_d = '0;
                end else begin
                    wr_x_en = 1'b1;
                    wr_y_en = 1'b1;
                    x_wr    = (load_sum >= ScreenW) ? 10'(load_sum - ScreenW) : 10'(load_sum);
                    if (idx_q == IdxLast) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StIdle: begin
                // restart takes priority over a simultaneous frame tick
                if (bus.restart) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end else if (bus.startOfFrame) begin
                    state_d = StMove;
                    idx_d   = '0;
                end
            end
            StMove: begin
                if (bus.restart) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end else begin
                    wr_x_en = 1'b1;
                    x_wr    = (move_sum >= ScreenW) ? 10'(move_sum - ScreenW) : 10'(move_sum);
                    if (idx_q == IdxLast) begin
                        idx_d        = '0;
                        state_d      = StIdle;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = StLoad;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StLoad;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Position storage carries no reset; it becomes valid once the first load pass completes.
    always_ff @(posedge CLK) begin
        if (!RST && wr_x_en) x_q[idx_q] <= x_wr;
        if (!RST && wr_y_en) y_q[idx_q] <= bus.start_offsetY[idx_q];
    end

    assign rd_oob = 32'(bus.rd_index) >= NUM_OF_LOGS;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            rd_x_q   <= '0;
            rd_y_q   <= '0;
        end else begin
            rd_ack_q <= bus.rd_valid;
            rd_err_q <= bus.rd_valid && rd_oob;
            if (bus.rd_valid) begin
                if (rd_oob) begin
                    rd_x_q <= '0;
                    rd_y_q <= '0;
                end else begin
                    rd_x_q <= x_q[bus.rd_index];
                    rd_y_q <= y_q[bus.rd_index];
                end
            end
        end
    end

    assign bus.ready      = (state_q == StIdle);
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.rd_x       = rd_x_q;
    assign bus.rd_y       = rd_y_q;
endmodule

// File: tb/tb_log_position_tracker.sv
// Directed bench for log_position_tracker: load timing, frame moves with wrap, overrun,
// restart abort, read port corner cases and mid-pass reset.
module tb_log_position_tracker;
    localparam int N = 30;
    localparam int W = 640;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    log_position_tracker_if #(.NUM_OF_LOGS(N)) bus ();

    log_position_tracker #(
        .NUM_OF_LOGS(N),
        .SCREEN_W   (W),
        .LOG_SPEED  (1)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int off_x [N];
    int off_y [N];
    int mdl_x [N];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input int i);
        bus.rd_valid = 1'b1;
        bus.rd_index = 5'(i);
        step();
        bus.rd_valid = 1'b0;
    endtask

    task automatic frame(output int cyc);
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        cyc = 1;
        while (!bus.frame_done && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic advance_model();
        for (int i = 0; i < N; i++) mdl_x[i] = (mdl_x[i] + 1) % W;
    endtask

    initial begin
        int cyc;
        int bad;
        int seen;

        bus.restart      = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.rd_valid     = 1'b0;
        bus.rd_index     = '0;
        for (int i = 0; i < N; i++) begin
            off_x[i] = (i == 0) ? 6 : (i == 5) ? 511 : (i * 37) % 512;
            off_y[i] = (i == 0) ? 255 : (i * 13 + 1) % 512;
            bus.start_offsetX[i] = 9'(off_x[i]);
            bus.start_offsetY[i] = 9'(off_y[i]);
            mdl_x[i] = off_x[i];
        end

        // reset state
        step();
        step();
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_rd_ack", 32'(bus.rd_ack), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_rd_x", 32'(bus.rd_x), 0);

        // initial load takes exactly N cycles
        rst = 1'b0;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!bus.ready && cyc < 40);
        chk("load_cycles", cyc, 30);

        rd(0);
        chk("rd0_ack", 32'(bus.rd_ack), 1);
        chk("rd0_x", 32'(bus.rd_x), 6);
        chk("rd0_y", 32'(bus.rd_y), 255);
        chk("rd0_err", 32'(bus.rd_err), 0);
        step();
        chk("ack_drop", 32'(bus.rd_ack), 0);
        chk("x_hold", 32'(bus.rd_x), 6);

        rd(30);
        chk("oob_ack", 32'(bus.rd_ack), 1);
        chk("oob_err", 32'(bus.rd_err), 1);
        chk("oob_x", 32'(bus.rd_x), 0);
        chk("oob_y", 32'(bus.rd_y), 0);
        rd(29);
        chk("rd29_err", 32'(bus.rd_err), 0);
        chk("rd29_x", 32'(bus.rd_x), 32'(off_x[29]));
        chk("rd29_y", 32'(bus.rd_y), 32'(off_y[29]));

        // first frame: timing and single-cycle frame_done
        frame(cyc);
        advance_model();
        chk("frame_cycles", cyc, 31);
        step();
        chk("frame_done_width", 32'(bus.frame_done), 0);

        // walk entry 5 from 511 up to 639
        bad = 0;
        for (int f = 0; f < 127; f++) begin
            frame(cyc);
            advance_model();
            if (cyc != 31) bad++;
        end
        chk("frames_timing", bad, 0);
        rd(5);
        chk("x5_at_639", 32'(bus.rd_x), 639);

        // wrap frame
        frame(cyc);
        advance_model();
        chk("wrap_frame_cycles", cyc, 31);
        step();
        chk("wrap_frame_done_width", 32'(bus.frame_done), 0);
        rd(5);
        chk("x5_wrapped", 32'(bus.rd_x), 0);
        for (int i = 0; i < N; i++) begin
            rd(i);
            chk($sformatf("wrap_x%0d", i), 32'(bus.rd_x), 32'(mdl_x[i]));
            chk($sformatf("wrap_y%0d", i), 32'(bus.rd_y), 32'(off_y[i]));
        end
        chk("no_overrun_yet", 32'(bus.overrun), 0);

        // stray tick while moving at idx 10
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        cyc = 1;
        while (!bus.frame_done && cyc < 40) begin
            bus.startOfFrame = (cyc == 11);
            step();
            cyc++;
        end
        bus.startOfFrame = 1'b0;
        advance_model();
        chk("overrun_frame_cycles", cyc, 31);
        chk("overrun_set", 32'(bus.overrun), 1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.frame_done) seen++;
        end
        chk("single_frame_done", seen, 0);
        rd(0);
        chk("overrun_x0", 32'(bus.rd_x), 32'(mdl_x[0]));
        rd(5);
        chk("overrun_x5", 32'(bus.rd_x), 32'(mdl_x[5]));

        // restart at MOVE idx 15
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        cyc = 1;
        seen = 0;
        while (cyc < 16) begin
            step();
            cyc++;
            if (bus.frame_done) seen++;
        end
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        cyc = 0;
        do begin
            step();
            cyc++;
            if (bus.frame_done) seen++;
        end while (!bus.ready && cyc < 40);
        chk("restart_load_cycles", cyc, 30);
        chk("restart_no_frame_done", seen, 0);
        for (int i = 0; i < N; i++) begin
            rd(i);
            chk($sformatf("reload_x%0d", i), 32'(bus.rd_x), 32'(off_x[i]));
            chk($sformatf("reload_y%0d", i), 32'(bus.rd_y), 32'(off_y[i]));
            mdl_x[i] = off_x[i];
        end
        chk("overrun_sticky", 32'(bus.overrun), 1);

        // read during MOVE returns the pre-update value, then reset at idx 20
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        rd(0);
        chk("pre_update_x0", 32'(bus.rd_x), 6);
        for (int k = 0; k < 19; k++) step();
        rst = 1'b1;
        step();
        chk("midrst_ready", 32'(bus.ready), 0);
        chk("midrst_frame_done", 32'(bus.frame_done), 0);
        chk("midrst_overrun", 32'(bus.overrun), 0);
        chk("midrst_rd_ack", 32'(bus.rd_ack), 0);
        chk("midrst_rd_err", 32'(bus.rd_err), 0);
        chk("midrst_rd_x", 32'(bus.rd_x), 0);
        chk("midrst_rd_y", 32'(bus.rd_y), 0);
        rst = 1'b0;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!bus.ready && cyc < 40);
        chk("midrst_load_cycles", cyc, 30);
        rd(0);
        chk("midrst_x0", 32'(bus.rd_x), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/log_position_tracker.md
LOG_POSITION_TRACKER -- requirements
Module: log_position_tracker

Interface
REQ-001 SHALL have parameter NUM_OF_LOGS, default 30, number of log entries tracked.
REQ-002 SHALL have parameter SCREEN_W, default 640, horizontal wrap modulus in pixels.
REQ-003 SHALL have parameter LOG_SPEED, default 1, pixels added per frame; legal range 1..SCREEN_W-1.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 start_offsetX  input  9 x NUM_OF_LOGS  initial X per log; sampled only during LOAD.
REQ-007 start_offsetY  input  9 x NUM_OF_LOGS  fixed Y per log; sampled only during LOAD.
REQ-008 restart  input  1  one-cycle request to reload all positions from the offsets.
REQ-009 startOfFrame  input  1  one-cycle frame tick; starts one MOVE pass.
REQ-010 rd_valid  input  1  read request for entry rd_index.
REQ-011 rd_index  input  5  entry to read.
REQ-012 ready  output  1  high in IDLE only.
REQ-013 frame_done  output  1  one-cycle pulse when a MOVE pass completes.
REQ-014 overrun  output  1  sticky: a startOfFrame arrived outside IDLE.
REQ-015 rd_ack  output  1  one-cycle response, registered, one cycle after rd_valid.
REQ-016 rd_x  output  10  X position of the requested entry (0..SCREEN_W-1).
REQ-017 rd_y  output  9  Y position of the requested entry.
REQ-018 rd_err  output  1  asserted with rd_ack when rd_index >= NUM_OF_LOGS.

Function
REQ-019 The block SHALL store per-entry x_pos (10 bits) and y_pos (9 bits) registers, plus a 5-bit index counter.
REQ-020 The FSM SHALL have states LOAD, IDLE and MOVE.
REQ-021 LOAD: each cycle x_pos[idx]<=start_offsetX[idx] and y_pos[idx]<=start_offsetY[idx], then idx++; the cycle with idx=NUM_OF_LOGS-1 goes to IDLE with idx<=0; total NUM_OF_LOGS cycles.
REQ-022 A loaded start_offsetX >= SCREEN_W SHALL be stored as start_offsetX-SCREEN_W.
REQ-023 IDLE: startOfFrame=1 SHALL go to MOVE with idx=0; restart=1 SHALL go to LOAD with idx=0; restart SHALL win if both are high.
REQ-024 MOVE: each cycle x_pos[idx]<=x_pos[idx]+LOG_SPEED, minus SCREEN_W if the sum >= SCREEN_W (wrap); y_pos SHALL be unchanged; idx++.
REQ-025 MOVE at idx=NUM_OF_LOGS-1 SHALL go to IDLE and pulse frame_done in the following cycle; a pass takes exactly NUM_OF_LOGS cycles.
REQ-026 restart in LOAD or MOVE SHALL abort the pass and re-enter LOAD at idx=0; it SHALL NOT produce a frame_done pulse.
REQ-027 startOfFrame in LOAD or MOVE SHALL be ignored (not queued) and SHALL set overrun; overrun SHALL be cleared only by RST.
REQ-028 The read port SHALL be served in every state.
  - rd_x/rd_y SHALL return register contents at the request cycle, i.e. the pre-update value for an entry written in that same cycle.
  - rd_index >= NUM_OF_LOGS: rd_ack=1, rd_err=1, rd_x=0, rd_y=0.
REQ-029 rd_x/rd_y SHALL hold their last value when rd_ack=0.
REQ-030 Arithmetic SHALL use 11-bit intermediates so that no overflow occurs for any legal LOG_SPEED.

Reset
REQ-031 RST=1 SHALL force state=LOAD, idx=0, ready=0, frame_done=0, overrun=0, rd_ack=0, rd_err=0, rd_x=0, rd_y=0 on the next edge, overriding all other inputs including mid-pass.
REQ-032 x_pos/y_pos need no reset value; they SHALL be valid after the first LOAD completes.

Verification
REQ-033 Release RST, offsetX[0]=6, offsetY[0]=255 -> ready rises exactly 30 cycles later; reading index 0 gives rd_x=6, rd_y=255, rd_ack=1 one cycle later.
REQ-034 x_pos[5]=639, LOG_SPEED=1, startOfFrame -> after frame_done, index 5 reads 0 and all other entries read +1; frame_done is high for exactly one cycle, 31 cycles after the tick.
REQ-035 startOfFrame pulsed at MOVE idx=10 -> pass completes unchanged, only one frame_done, overrun=1 and stays high until RST.
REQ-036 restart at MOVE idx=15 -> LOAD restarts, no frame_done, all entries equal their offsets once ready rises.
REQ-037 rd_index=30 -> rd_ack=1, rd_err=1, rd_x=0, rd_y=0; rd_index=29 -> rd_err=0.
REQ-038 RST asserted at MOVE idx=20 -> next cycle all outputs are at reset values and the state is LOAD idx=0.
